rle_uart_packer: RTL

Downstream neighbour of the row compressor: takes its per-sample Y/U/V byte stream with pixel coordinates, run-length encodes consecutive equal values per channel, and packs each run into a 5-byte packet. Packets are serialized directly onto the UART TX pin, 8N1, LSB first. Backpressure to the compressor is a valid/ready handshake.

---
 rtl/rle_uart_packer_if.sv | 13 +
 rtl/rle_uart_packer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rle_uart_packer_if.sv
// Sample handshake between the row compressor (master) and rle_uart_packer (slave).
interface rle_uart_packer_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic [1:0] i_chan;
  logic [9:0] i_x;
  logic [8:0] i_y;
  logic       i_eol;
  logic       o_ready;

  modport master (output i_valid, i_data, i_chan, i_x, i_y, i_eol, input o_ready);
  modport slave  (input i_valid, i_data, i_chan, i_x, i_y, i_eol, output o_ready);
endinterface

// File: rtl/rle_uart_packer.sv
// Per-channel run-length encoder packing runs into 5-byte packets sent 8N1 on o_tx.
// Define PACKER_PARITY_EN to send 8E1 frames instead.
//
// state    | meaning
// ST_RESET | one cycle after reset release, clears trackers
// ST_RUN   | accepting samples
// ST_FLUSH | end of row, emitting active trackers Y, U, V in order
module rle_uart_packer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RUN_MAX      = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  rle_uart_packer_if.slave  s,
  output logic              o_tx,
  output logic              o_busy,
  output logic [15:0]       o_pkt_count
);

`ifdef PACKER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [5:0]    PKT_BITS  = 6'(5 * FRAME_BITS);
  localparam logic [3:0]    FPOS_LAST = 4'(FRAME_BITS - 1);
  localparam logic [9:0]    RUN_MAX_L = 10'(RUN_MAX);
  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FLUSH} state_t;

  state_t      state;
  logic [1:0]  fl_ch;
  logic        pkt_pending;
  logic [39:0] pkt;

  logic        trk_active [3];
  logic [7:0]  trk_val    [3];
  logic [9:0]  trk_x      [3];
  logic [8:0]  trk_y      [3];
  logic [9:0]  trk_len    [3];

  logic          ser_active;
  logic          ser_load;
  logic [39:0]   sh;
  logic [TW-1:0] timer;
  logic [5:0]    bits_left;
  logic [3:0]    fpos;
`ifdef PACKER_PARITY_EN
  logic          par;
`endif

  logic accept;

  assign s.o_ready = (state == ST_RUN) && !pkt_pending;
  assign accept    = s.i_valid && s.o_ready;
  assign ser_load  = pkt_pending && !ser_active;
  assign o_busy    = pkt_pending || ser_active;

  // Byte 0 lands in bits [7:0] so the serializer can shift straight out.
  function automatic logic [39:0] pack(input logic [1:0] ch, input logic [7:0] val,
                                       input logic [9:0] x, input logic [8:0] y,
                                       input logic [9:0] len);
    return {len[7:0], val, {1'b0, len[9:8], ch, y[8], x[9:8]}, y[7:0], x[7:0]};
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_RESET;
      fl_ch       <= 2'd0;
      pkt_pending <= 1'b0;
      pkt         <= '0;
      for (int i = 0; i < 3; i++) begin
        trk_active[i] <= 1'b0;
        trk_val[i]    <= '0;
        trk_x[i]      <= '0;
        trk_y[i]      <= '0;
        trk_len[i]    <= '0;
      end
    end else begin
      if (ser_load) pkt_pending <= 1'b0;
      case (state)
        ST_RESET: begin
          for (int i = 0; i < 3; i++) trk_active[i] <= 1'b0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (s.i_chan != 2'd3) begin
              if (trk_active[s.i_chan] && trk_val[s.i_chan] == s.i_data &&
                  trk_y[s.i_chan] == s.i_y && trk_len[s.i_chan] < RUN_MAX_L) begin
                trk_len[s.i_chan] <= trk_len[s.i_chan] + 10'd1;
              end else begin
                if (trk_active[s.i_chan]) begin
                  pkt         <= pack(s.i_chan, trk_val[s.i_chan], trk_x[s.i_chan],
                                      trk_y[s.i_chan], trk_len[s.i_chan]);
                  pkt_pending <= 1'b1;
                end
                trk_active[s.i_chan] <= 1'b1;
                trk_val[s.i_chan]    <= s.i_data;
                trk_x[s.i_chan]      <= s.i_x;
                trk_y[s.i_chan]      <= s.i_y;
                trk_len[s.i_chan]    <= 10'd1;
              end
            end
            if (s.i_eol) begin
              state <= ST_FLUSH;
              fl_ch <= 2'd0;
            end
          end
        end
        ST_FLUSH: begin
          // An active tracker holds here until the holding register is free.
          if (!trk_active[fl_ch] || !pkt_pending) begin
            if (trk_active[fl_ch]) begin
              pkt               <= pack(fl_ch, trk_val[fl_ch], trk_x[fl_ch],
                                        trk_y[fl_ch], trk_len[fl_ch]);
              pkt_pending       <= 1'b1;
              trk_active[fl_ch] <= 1'b0;
            end
            if (fl_ch == 2'd2) state <= ST_RUN;
            else               fl_ch <= fl_ch + 2'd1;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  // The load cycle leaves timer at zero so the start bit appears on the next edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ser_active  <= 1'b0;
      o_tx        <= 1'b1;
      o_pkt_count <= 16'd0;
      sh          <= '0;
      timer       <= '0;
      bits_left   <= 6'd0;
      fpos        <= 4'd0;
`ifdef PACKER_PARITY_EN
      par         <= 1'b0;
`endif
    end else if (ser_load) begin
      ser_active <= 1'b1;
      sh         <= pkt;
      timer      <= '0;
      bits_left  <= PKT_BITS;
      fpos       <= 4'd0;
    end else if (ser_active) begin
      if (timer != '0) begin
        timer <= timer - TW'(1);
      end else if (bits_left == 6'd0) begin
        ser_active  <= 1'b0;
        o_tx        <= 1'b1;
        o_pkt_count <= o_pkt_count + 16'd1;
      end else begin
        timer     <= BIT_LAST;
        bits_left <= bits_left - 6'd1;
        fpos      <= (fpos == FPOS_LAST) ? 4'd0 : fpos + 4'd1;
        if (fpos == 4'd0) begin
          o_tx <= 1'b0;
`ifdef PACKER_PARITY_EN
          par  <= ^sh[7:0];
`endif
        end else if (fpos <= 4'd8) begin
          o_tx <= sh[0];
          sh   <= {1'b0, sh[39:1]};
`ifdef PACKER_PARITY_EN
        end else if (fpos == 4'd9) begin
          o_tx <= par;
`endif
        end else begin
          o_tx <= 1'b1;
        end
      end
    end
  end

endmodule
